// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: geometry, bus widths and the write-port arbiter state encoding.
package fb_pkg;
  localparam int ADDR_W   = 14;
  localparam int DATA_W   = 8;
  localparam int FB_BYTES = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    CLEAR = 2'd3
  } arb_state_e;
endpackage

// File: rtl/fb_clear_sweeper.sv
// Clear-screen sweeper: after a start pulse emits one CLEAR_VALUE write per cycle over the
// whole framebuffer, then flags done for one cycle.
module fb_clear_sweeper #(
  parameter int                 ADDR_W      = fb_pkg::ADDR_W,
  parameter int                 DATA_W      = fb_pkg::DATA_W,
  parameter int                 FB_BYTES    = fb_pkg::FB_BYTES,
  parameter logic [DATA_W-1:0]  CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              w_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);
  localparam int CNT_W = $clog2(FB_BYTES);

  logic [CNT_W-1:0] cnt;
  logic             active;
  logic             last;

  // last marks the spare cycle after the final write, so done follows the last write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      last   <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      last   <= 1'b0;
      cnt    <= '0;
    end else if (active) begin
      if (last) begin
        active <= 1'b0;
        last   <= 1'b0;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
        if (cnt == CNT_W'(FB_BYTES - 1)) last <= 1'b1;
      end
    end
  end

  assign busy = active;
  assign done = active && last;
  assign w_en = active && !last;
  assign addr = ADDR_W'(cnt);
  assign data = CLEAR_VALUE;
endmodule

// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port arbiter: burst-granular round-robin between two writer clients,
// with a clear-screen sweep taking priority whenever the port is idle.
module fb_write_arbiter #(
  parameter int                 ADDR_W      = fb_pkg::ADDR_W,
  parameter int                 DATA_W      = fb_pkg::DATA_W,
  parameter int                 FB_BYTES    = fb_pkg::FB_BYTES,
  parameter logic [DATA_W-1:0]  CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_c0_req,
  input  logic              i_c0_w_en,
  input  logic [ADDR_W-1:0] i_c0_addr,
  input  logic [DATA_W-1:0] i_c0_data,
  output logic              o_c0_gnt,
  input  logic              i_c1_req,
  input  logic              i_c1_w_en,
  input  logic [ADDR_W-1:0] i_c1_addr,
  input  logic [DATA_W-1:0] i_c1_data,
  output logic              o_c1_gnt,
  input  logic              i_clear_start,
  output logic              o_clear_busy,
  output logic [ADDR_W-1:0] o_ram_address,
  output logic [DATA_W-1:0] o_ram_data,
  output logic              o_w_en,
  output logic              o_drop
);
  import fb_pkg::*;

  arb_state_e state, next_state;
  logic clear_pending, next_pending;
  logic last_served, next_last;
  logic sweep_start, sweep_busy, sweep_done, sweep_w_en;
  logic [ADDR_W-1:0] sweep_addr;
  logic [DATA_W-1:0] sweep_data;

  logic              wr_en_p0;
  logic [ADDR_W-1:0] wr_addr_p0;
  logic [DATA_W-1:0] wr_data_p0;
  logic              drop_p0;

  logic              wr_en_p1;
  logic [ADDR_W-1:0] wr_addr_p1;
  logic [DATA_W-1:0] wr_data_p1;
  logic              drop_p1;

  fb_clear_sweeper #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .FB_BYTES    (FB_BYTES),
    .CLEAR_VALUE (CLEAR_VALUE)
  ) u_sweeper (
    .clk   (clk),
    .rst   (rst),
    .start (sweep_start),
    .busy  (sweep_busy),
    .done  (sweep_done),
    .w_en  (sweep_w_en),
    .addr  (sweep_addr),
    .data  (sweep_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      clear_pending <= 1'b0;
      last_served   <= 1'b1;
    end else begin
      state         <= next_state;
      clear_pending <= next_pending;
      last_served   <= next_last;
    end
  end

  // A start seen in IDLE goes straight to CLEAR; elsewhere it is parked unless a sweep is running
  always_comb begin
    next_state   = state;
    next_pending = clear_pending;
    next_last    = last_served;
    sweep_start  = 1'b0;
    if (i_clear_start && state != CLEAR) next_pending = 1'b1;
    case (state)
      IDLE: begin
        if (clear_pending || i_clear_start) begin
          next_state   = CLEAR;
          next_pending = 1'b0;
          sweep_start  = 1'b1;
        end else if (i_c0_req && (!i_c1_req || last_served)) begin
          next_state = GNT0;
          next_last  = 1'b0;
        end else if (i_c1_req) begin
          next_state = GNT1;
          next_last  = 1'b1;
        end
      end
      GNT0:    if (!i_c0_req) next_state = IDLE;
      GNT1:    if (!i_c1_req) next_state = IDLE;
      CLEAR:   if (sweep_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // p0: select the write source owned by the current state
  always_comb begin
    wr_en_p0   = 1'b0;
    wr_addr_p0 = i_c0_addr;
    wr_data_p0 = i_c0_data;
    case (state)
      GNT0: wr_en_p0 = i_c0_req && i_c0_w_en;
      GNT1: begin
        wr_en_p0   = i_c1_req && i_c1_w_en;
        wr_addr_p0 = i_c1_addr;
        wr_data_p0 = i_c1_data;
      end
      CLEAR: begin
        wr_en_p0   = sweep_w_en;
        wr_addr_p0 = sweep_addr;
        wr_data_p0 = sweep_data;
      end
      default: wr_en_p0 = 1'b0;
    endcase
  end

  assign drop_p0 = (i_c0_w_en && state != GNT0) || (i_c1_w_en && state != GNT1);

  // p1: registered RAM port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_p1   <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
      drop_p1    <= 1'b0;
    end else begin
      wr_en_p1 <= wr_en_p0;
      drop_p1  <= drop_p0;
      if (wr_en_p0) begin
        wr_addr_p1 <= wr_addr_p0;
        wr_data_p1 <= wr_data_p0;
      end
    end
  end

  assign o_c0_gnt      = (state == GNT0);
  assign o_c1_gnt      = (state == GNT1);
  assign o_clear_busy  = clear_pending || (state == CLEAR) || sweep_busy;
  assign o_w_en        = wr_en_p1;
  assign o_ram_address = wr_addr_p1;
  assign o_ram_data    = wr_data_p1;
  assign o_drop        = drop_p1;
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: a vector table for arbitration and write routing,
// then hand-written sequences for bursts, clear sweeps and reset mid-sweep.
module tb_fb_write_arbiter;
  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  logic        clk = 1'b0;
  logic        rst;
  logic        c0_req, c0_we, c1_req, c1_we, clr;
  logic [13:0] c0_addr, c1_addr;
  logic [7:0]  c0_data, c1_data;
  logic        gnt0, gnt1, busy, w_en, drop;
  logic [13:0] ram_addr;
  logic [7:0]  ram_data;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic req0; logic we0; logic [13:0] a0; logic [7:0] d0;
    logic req1; logic we1; logic [13:0] a1; logic [7:0] d1;
    logic clr;
    logic e_gnt0; logic e_gnt1; logic e_wen; logic [13:0] e_addr; logic [7:0] e_data;
    logic e_drop; logic e_busy;
  } vec_t;

  vec_t vecs [14];

  fb_write_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .i_c0_req      (c0_req),
    .i_c0_w_en     (c0_we),
    .i_c0_addr     (c0_addr),
    .i_c0_data     (c0_data),
    .o_c0_gnt      (gnt0),
    .i_c1_req      (c1_req),
    .i_c1_w_en     (c1_we),
    .i_c1_addr     (c1_addr),
    .i_c1_data     (c1_data),
    .o_c1_gnt      (gnt1),
    .i_clear_start (clr),
    .o_clear_busy  (busy),
    .o_ram_address (ram_addr),
    .o_ram_data    (ram_data),
    .o_w_en        (w_en),
    .o_drop        (drop)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    c0_req = 0; c0_we = 0; c0_addr = '0; c0_data = '0;
    c1_req = 0; c1_we = 0; c1_addr = '0; c1_data = '0;
    clr = 0;
  endtask

  initial begin
    int nwr, n, addr_err, first_cyc, last_cyc, falls, fall_cyc, gnt_cyc, early;
    logic prev_busy, pulsed;

    //              req0 we0 a0      d0     req1 we1 a1      d1     clr | gnt0 gnt1 wen addr    data   drop busy
    vecs[0]  = '{T, F, 14'h000, 8'h00, T, F, 14'h000, 8'h00, F, T, F, F, 14'h000, 8'h00, F, F};
    vecs[1]  = '{T, T, 14'h010, 8'h11, T, F, 14'h000, 8'h00, F, T, F, T, 14'h010, 8'h11, F, F};
    vecs[2]  = '{T, F, 14'h000, 8'h00, T, T, 14'h055, 8'h99, F, T, F, F, 14'h000, 8'h00, T, F};
    vecs[3]  = '{F, F, 14'h000, 8'h00, T, F, 14'h000, 8'h00, F, F, F, F, 14'h000, 8'h00, F, F};
    vecs[4]  = '{F, F, 14'h000, 8'h00, T, F, 14'h000, 8'h00, F, F, T, F, 14'h000, 8'h00, F, F};
    vecs[5]  = '{F, F, 14'h000, 8'h00, T, T, 14'h020, 8'h22, F, F, T, T, 14'h020, 8'h22, F, F};
    vecs[6]  = '{T, F, 14'h000, 8'h00, F, F, 14'h000, 8'h00, F, F, F, F, 14'h000, 8'h00, F, F};
    vecs[7]  = '{T, F, 14'h000, 8'h00, T, F, 14'h000, 8'h00, F, T, F, F, 14'h000, 8'h00, F, F};
    vecs[8]  = '{F, T, 14'h030, 8'h33, T, F, 14'h000, 8'h00, F, F, F, F, 14'h000, 8'h00, F, F};
    vecs[9]  = '{T, F, 14'h000, 8'h00, T, F, 14'h000, 8'h00, F, F, T, F, 14'h000, 8'h00, F, F};
    vecs[10] = '{T, T, 14'h044, 8'h44, T, F, 14'h000, 8'h00, F, F, T, F, 14'h000, 8'h00, T, F};
    vecs[11] = '{F, F, 14'h000, 8'h00, F, F, 14'h000, 8'h00, F, F, F, F, 14'h000, 8'h00, F, F};
    vecs[12] = '{T, F, 14'h000, 8'h00, F, F, 14'h000, 8'h00, T, F, F, F, 14'h000, 8'h00, F, T};
    vecs[13] = '{T, F, 14'h000, 8'h00, F, F, 14'h000, 8'h00, F, F, F, T, 14'h000, 8'h00, F, T};

    idle_inputs();
    rst = 1;
    tick();
    tick();
    check("reset_gnt0", gnt0, 0);
    check("reset_gnt1", gnt1, 0);
    check("reset_wen", w_en, 0);
    check("reset_addr", ram_addr, 0);
    check("reset_data", ram_data, 0);
    check("reset_drop", drop, 0);
    check("reset_busy", busy, 0);
    rst = 0;
    tick();

    for (int i = 0; i < 14; i++) begin
      c0_req = vecs[i].req0; c0_we = vecs[i].we0; c0_addr = vecs[i].a0; c0_data = vecs[i].d0;
      c1_req = vecs[i].req1; c1_we = vecs[i].we1; c1_addr = vecs[i].a1; c1_data = vecs[i].d1;
      clr = vecs[i].clr;
      tick();
      check($sformatf("vec%0d_gnt0", i), gnt0, vecs[i].e_gnt0);
      check($sformatf("vec%0d_gnt1", i), gnt1, vecs[i].e_gnt1);
      check($sformatf("vec%0d_wen", i), w_en, vecs[i].e_wen);
      check($sformatf("vec%0d_drop", i), drop, vecs[i].e_drop);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      if (vecs[i].e_wen) begin
        check($sformatf("vec%0d_addr", i), ram_addr, vecs[i].e_addr);
        check($sformatf("vec%0d_data", i), ram_data, vecs[i].e_data);
      end
    end
    clr = 0;

    // Clear started with a pending req: the remaining sweep runs, then client 0 is granted
    nwr = 0; n = 0;
    while (busy && n < 1100) begin
      tick();
      if (w_en) nwr++;
      if (gnt0) early++;
      n++;
    end
    check("sweep_rest_writes", nwr, 1023);
    check("sweep_busy_low", busy, 0);
    check("req_waits_gnt0", gnt0, 0);
    tick();
    check("req_after_clear_gnt0", gnt0, 1);
    c0_req = 0;
    tick();
    check("release_gnt0", gnt0, 0);

    // Client 0 burst of 16 writes
    c0_req = 1;
    n = 0;
    tick();
    while (!gnt0 && n < 10) begin tick(); n++; end
    check("burst_gnt0", gnt0, 1);
    for (int i = 0; i < 16; i++) begin
      c0_we = 1; c0_addr = 14'(i); c0_data = 8'(8'hA0 + i);
      tick();
      check($sformatf("burst%0d_wen", i), w_en, 1);
      check($sformatf("burst%0d_addr", i), ram_addr, i);
      check($sformatf("burst%0d_data", i), ram_data, 8'hA0 + i);
    end
    c0_we = 0; c0_req = 0;
    tick();
    check("burst_release_gnt0", gnt0, 0);
    check("burst_release_wen", w_en, 0);
    tick();

    // Clear start during a burst, client 1 waiting, second start mid-sweep
    c0_req = 1;
    tick();
    check("b_gnt0", gnt0, 1);
    c0_we = 1; c0_addr = 14'h100; c0_data = 8'h5A; clr = 1;
    tick();
    clr = 0;
    check("b_busy_rise", busy, 1);
    check("b_gnt0_held", gnt0, 1);
    check("b_write_addr", ram_addr, 14'h100);
    for (int i = 1; i < 4; i++) begin
      c0_addr = 14'(14'h100 + i); c0_data = 8'(8'h5A + i);
      tick();
      check($sformatf("b_burst%0d_addr", i), ram_addr, 14'h100 + i);
      check($sformatf("b_burst%0d_data", i), ram_data, 8'h5A + i);
      check($sformatf("b_burst%0d_gnt0", i), gnt0, 1);
    end
    c0_we = 0; c0_req = 0; c1_req = 1;
    tick();
    check("b_release_gnt0", gnt0, 0);
    check("b_busy_pending", busy, 1);
    nwr = 0; addr_err = 0; first_cyc = -1; last_cyc = -1; falls = 0; fall_cyc = -1;
    gnt_cyc = -1; early = 0; prev_busy = busy; pulsed = 0;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      clr = 0;
      if (nwr == 512 && !pulsed) begin clr = 1; pulsed = 1; end
      tick();
      if (w_en) begin
        if (ram_addr != 14'(nwr) || ram_data != 8'h00) addr_err++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        nwr++;
      end
      if (prev_busy && !busy) begin falls++; fall_cyc = cyc; end
      prev_busy = busy;
      if (gnt1 && busy) early++;
      if (gnt1) begin gnt_cyc = cyc; break; end
    end
    clr = 0;
    check("sweep_total_writes", nwr, 1024);
    check("sweep_addr_data_errors", addr_err, 0);
    check("sweep_consecutive", last_cyc - first_cyc, 1023);
    check("sweep_busy_falls", falls, 1);
    check("sweep_busy_after_last", fall_cyc - last_cyc, 1);
    check("sweep_gnt1_early", early, 0);
    check("sweep_gnt1_after", gnt_cyc - fall_cyc, 1);
    c1_req = 0;
    tick();
    check("c1_release", gnt1, 0);
    tick();

    // Clear from IDLE with exact latency, reset at address 0x200
    clr = 1;
    tick();
    clr = 0;
    check("c_busy_k", busy, 1);
    check("c_wen_k", w_en, 0);
    tick();
    check("c_first_wen", w_en, 1);
    check("c_first_addr", ram_addr, 0);
    n = 0;
    while (!(w_en && ram_addr == 14'h200) && n < 1100) begin tick(); n++; end
    check("c_reach_200", ram_addr, 14'h200);
    #2 rst = 1;
    #1;
    check("arst_wen", w_en, 0);
    check("arst_addr", ram_addr, 0);
    check("arst_busy", busy, 0);
    check("arst_gnt", {gnt0, gnt1, drop}, 0);
    tick();
    rst = 0;
    nwr = 0; falls = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      tick();
      if (w_en) nwr++;
      if (busy) falls++;
    end
    check("post_rst_writes", nwr, 0);
    check("post_rst_busy", falls, 0);
    c0_req = 1; c1_req = 1;
    tick();
    check("post_rst_tie_gnt0", gnt0, 1);
    check("post_rst_tie_gnt1", gnt1, 0);
    idle_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
